// File: rtl/interfaz_tx.sv
// -----------------------------------------------------------------------------
// interfaz_tx
//
// Return-path interface between the ALU and the UART transmitter. A result is
// captured on a one-cycle valid pulse, then sent as NB_RESULT/DBIT bytes,
// least-significant byte first, using a start/done handshake with the UART.
// Valids that arrive while a result is still being sent are dropped and
// flagged on o_overrun.
//
// NB_RESULT must be an integer multiple of DBIT, giving 1..8 bytes.
//
// Ports:
//   i_clk          : system clock, rising edge
//   i_rst          : asynchronous reset, active low
//   i_result       : ALU result, sampled only on the accepting edge
//   i_result_valid : one-cycle "result ready" pulse
//   i_tx_done      : one-cycle pulse from the UART at the end of the stop bit
//   o_tx_data      : byte presented to the UART, held for the whole transfer
//   o_tx_start     : one-cycle start pulse to the UART
//   o_busy         : high while a result is being sent
//   o_overrun      : one-cycle pulse after a dropped result
// -----------------------------------------------------------------------------
module interfaz_tx #(
    parameter int DBIT      = 8,
    parameter int NB_RESULT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NB_RESULT-1:0] i_result,
    input  logic                 i_result_valid,
    input  logic                 i_tx_done,
    output logic [DBIT-1:0]      o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int NBYTES = NB_RESULT / DBIT;
    localparam int CNT_W  = $clog2(NBYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                 state_q;
    logic [NB_RESULT-1:0]   sreg_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DBIT-1:0]        tx_data_q;
    logic                   overrun_q;

    // Next byte moves into the low DBIT bits; upper bits fill with zeros.
    logic [NB_RESULT-1:0]   sreg_shift_d;
    assign sreg_shift_d = sreg_q >> DBIT;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            // Any valid outside IDLE is dropped; the transfer is untouched.
            overrun_q <= i_result_valid && (state_q != ST_IDLE);

            case (state_q)
                ST_IDLE: begin
                    if (i_result_valid) begin
                        sreg_q    <= i_result;
                        cnt_q     <= '0;
                        tx_data_q <= i_result[DBIT-1:0];
                        state_q   <= ST_SEND;
                    end
                end
                // A done here cannot belong to us: nothing has been started yet.
                ST_SEND: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_IDLE;
                        end else begin
                            sreg_q    <= sreg_shift_d;
                            cnt_q     <= cnt_q + CNT_W'(1);
                            tx_data_q <= sreg_shift_d[DBIT-1:0];
                            state_q   <= ST_SEND;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers: no input-to-output path.
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = (state_q == ST_SEND);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_interfaz_tx.sv
// -----------------------------------------------------------------------------
// tb_interfaz_tx
//
// Bench for interfaz_tx with a 16-bit result (two bytes). A transaction-level
// model keeps a queue of bytes still owed to the UART and checks start, busy,
// overrun and data once per cycle. A simple UART model answers each start
// with a done pulse a configurable number of cycles later.
// -----------------------------------------------------------------------------
module tb_interfaz_tx;

    localparam int DBIT   = 8;
    localparam int NBR    = 16;
    localparam int NBYTES = NBR / DBIT;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NBR-1:0]  result = '0;
    logic            valid = 1'b0;
    logic            done = 1'b0;
    logic [DBIT-1:0] tx_data;
    logic            tx_start;
    logic            busy;
    logic            overrun;

    interfaz_tx #(
        .DBIT      (DBIT),
        .NB_RESULT (NBR)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_result       (result),
        .i_result_valid (valid),
        .i_tx_done      (done),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_busy         (busy),
        .o_overrun      (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit              m_busy;
    bit              m_send;      // a start was issued last cycle
    logic [DBIT-1:0] m_q[$];      // bytes not yet started
    logic [DBIT-1:0] m_data;      // byte the UART should currently see
    int              timer = 0;   // UART model countdown to done
    int              lat   = 20;
    int              n_start = 0;

    task automatic model_reset();
        m_busy = 1'b0;
        m_send = 1'b0;
        m_q.delete();
        m_data = '0;
    endtask

    // One clock cycle: drive inputs, let the edge happen, check outputs.
    task automatic step(input bit v, input logic [NBR-1:0] r, input bit xd);
        bit d;
        bit exp_start;
        bit exp_ovr;
        d      = (timer == 1) || xd;
        valid  = v;
        result = r;
        done   = d;
        @(posedge clk);
        #1;
        if (timer > 0) timer--;
        exp_start = 1'b0;
        exp_ovr   = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_ovr = v && m_busy;
            if (!m_busy) begin
                if (v) begin
                    for (int k = 0; k < NBYTES; k++) m_q.push_back(r[k*DBIT +: DBIT]);
                    m_busy    = 1'b1;
                    exp_start = 1'b1;
                    m_data    = m_q.pop_front();
                end
            end else if (!m_send && d) begin
                if (m_q.size() == 0) begin
                    m_busy = 1'b0;
                end else begin
                    exp_start = 1'b1;
                    m_data    = m_q.pop_front();
                end
            end
            m_send = exp_start;
        end
        chk("start",   {31'b0, tx_start}, {31'b0, exp_start});
        chk("busy",    {31'b0, busy},     {31'b0, m_busy});
        chk("overrun", {31'b0, overrun},  {31'b0, exp_ovr});
        chk("data",    {24'b0, tx_data},  {24'b0, m_data});
        if (tx_start) begin
            n_start++;
            timer = lat;
            $display("t=%0t tx byte %02h", $time, tx_data);
        end
        valid = 1'b0;
        done  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || timer != 0) && n < 500) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk("idle_bound", {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"},   {31'b0, tx_start}, 32'd0);
        chk({tag, "_busy"},    {31'b0, busy},     32'd0);
        chk({tag, "_overrun"}, {31'b0, overrun},  32'd0);
        chk({tag, "_data"},    {24'b0, tx_data},  32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (4) step(1'b0, '0, 1'b0);

        // Two-byte result, UART done 20 cycles after start
        lat = 20;
        s0 = n_start;
        step(1'b1, 16'hBEEF, 1'b0);
        wait_idle();
        chk("beef_starts", n_start - s0, 2);

        // Overrun during WAIT: 16'hFFFF must never reach the UART
        s0 = n_start;
        step(1'b1, 16'h1234, 1'b0);
        repeat (5) step(1'b0, '0, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'hFFFF, 1'b0);
        wait_idle();
        chk("ovr_starts", n_start - s0, 2);

        // Valid coincident with the final done is dropped
        lat = 6;
        s0 = n_start;
        step(1'b1, 16'h5566, 1'b0);
        n = 0;
        while (!(timer == 1 && m_q.size() == 0 && !m_send && m_busy) && n < 200) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        step(1'b1, 16'h7777, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        chk("coinc_starts", n_start - s0, 2);

        // Spurious done in IDLE and in SEND
        s0 = n_start;
        repeat (3) step(1'b0, '0, 1'b1);
        step(1'b1, 16'hA1B2, 1'b0);
        step(1'b0, '0, 1'b1);
        wait_idle();
        chk("spur_starts", n_start - s0, 2);

        // Asynchronous reset during the first byte of 16'hCAFE
        lat = 20;
        step(1'b1, 16'hCAFE, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk_zero("async");
        model_reset();
        repeat (2) step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        s0 = n_start;
        repeat (20) step(1'b0, '0, 1'b0);
        chk("rst_nostart", n_start - s0, 0);
        s0 = n_start;
        step(1'b1, 16'h0102, 1'b0);
        wait_idle();
        chk("post_rst_starts", n_start - s0, 2);

        // Randomized results, latencies and stray valids
        for (int it = 0; it < 40; it++) begin
            logic [NBR-1:0] r;
            r   = NBR'($urandom);
            lat = $urandom_range(2, 12);
            if ($urandom_range(0, 3) == 0) step(1'b0, '0, 1'b1);
            s0 = n_start;
            step(1'b1, r, 1'b0);
            n = 0;
            while ((busy || timer != 0) && n < 300) begin
                step($urandom_range(0, 9) == 0, NBR'($urandom), 1'b0);
                n++;
            end
            chk("rand_starts", n_start - s0, 2);
            repeat ($urandom_range(0, 3)) step(1'b0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interfaz_tx.md
# interfaz_tx

Return-path interface between the ALU and the UART transmitter. It captures an ALU result on a one-cycle valid pulse and splits it into DBIT-wide bytes, least-significant byte first. It hands each byte to the UART transmitter with a start/done handshake. It is the counterpart of the receive-side interface that assembles A, B and the opcode from UART bytes.

## Interface
Parameters:
- DBIT, 8: UART data width; also the byte width sent per transfer.
- NB_RESULT, 8: ALU result width. Must be an integer multiple of DBIT.
- NBYTES = NB_RESULT/DBIT: number of bytes per result, 1..8. This is a local parameter, not overridable.

Ports:
- i_clk, in, 1: single system clock; rising edge.
- i_rst, in, 1: reset, asynchronous, active-low.
- i_result, in, NB_RESULT: ALU result. Sampled only on the accepting edge.
- i_result_valid, in, 1: one-cycle pulse meaning "result ready". Typically the receive interface's done pulse delayed to match ALU latency.
- i_tx_done, in, 1: one-cycle pulse from the UART transmitter at the end of the stop bit.
- o_tx_data, out, DBIT: byte presented to the UART transmitter. Held stable for the whole transfer.
- o_tx_start, out, 1: one-cycle start pulse to the UART transmitter.
- o_busy, out, 1: high while a result is being sent.
- o_overrun, out, 1: one-cycle pulse when a result is dropped.

## Operation
- Internal state:
  - shift register `sreg`, NB_RESULT bits;
  - byte counter `cnt`, width clog2(NBYTES)+1;
  - a 3-state FSM.
- Reset (async assert): FSM to IDLE; sreg=0, cnt=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_overrun=0.
- **IDLE**
  - o_busy=0.
  - On i_result_valid: sreg<=i_result, cnt<=0, go to SEND.
  - i_tx_done is ignored.
- **SEND**
  - o_tx_start=1 for exactly this cycle; o_busy=1.
  - o_tx_data=sreg[DBIT-1:0].
  - Unconditionally go to WAIT.
  - An i_tx_done in this cycle is ignored, since no transfer is outstanding yet.
- **WAIT**
  - o_busy=1; o_tx_data is held.
  - On i_tx_done with cnt==NBYTES-1: go to IDLE.
  - On i_tx_done otherwise: sreg<=sreg>>DBIT (zero fill), cnt<=cnt+1, go to SEND.
- **Byte order:** byte k sent is i_result[k*DBIT +: DBIT], k=0..NBYTES-1.
- **Overrun:** i_result_valid seen in SEND or WAIT is dropped.
  - o_overrun is registered high for the following cycle.
  - The transfer in progress is unaffected; sreg is not overwritten.
- o_tx_start and o_busy are decoded from the state register only. No combinational path exists from any input to any output.
- o_tx_data is a registered copy of sreg[DBIT-1:0], updated on the same edge as sreg.

## Timing
- Result latch: i_result_valid sampled high at edge E → SEND during E..E+1 → o_tx_start high in that cycle, o_tx_data valid from E.
- Per-byte sequence:
  - o_tx_start pulse.
  - UART transmission time.
  - i_tx_done sampled at edge D.
  - Next byte's o_tx_start high in cycle D..D+1 (one-cycle turnaround).
- The final i_tx_done at edge D returns the FSM to IDLE. o_busy falls after D. A new i_result_valid is accepted at edge D+1 or later.
- Simultaneous events:
  - i_result_valid arriving in the same cycle as the final i_tx_done is still in WAIT, so it is dropped and flagged as overrun.
  - Upstream must gate on !o_busy.
- o_overrun rises one edge after the dropped valid. Consecutive dropped valids give consecutive pulses.
- Reset mid-transfer clears everything immediately. A later i_tx_done from the UART finishing its byte arrives in IDLE and is ignored. No restart occurs.
- Minimum time between accepted results: NBYTES*(2 + UART byte time) cycles.

## Test plan
- Reset values: hold i_rst=0 mid-simulation, asynchronously between edges → all outputs 0 immediately. After release, no o_tx_start without i_result_valid.
- Single byte (NB_RESULT=8): i_result=8'hA5 with valid pulse → exactly one o_tx_start, o_tx_data=8'hA5, one cycle after the valid edge. o_busy drops one edge after i_tx_done.
- Multi-byte (NB_RESULT=16, UART model done 20 cycles after start): i_result=16'hBEEF → o_tx_data 8'hEF then 8'hBE. The second o_tx_start comes exactly one cycle after the first i_tx_done. Exactly two starts in total.
- Overrun: during the WAIT of 16'h1234, pulse valid with 16'hFFFF → o_overrun one-cycle pulse; output is still 8'h34, 8'h12; 16'hFFFF is never sent.
- Edge cases: valid coincident with the final i_tx_done → dropped plus overrun. Spurious i_tx_done in IDLE and in SEND → no state change, no extra start.
- Reset mid-transfer: assert i_rst during the WAIT of the first byte of 16'hCAFE, release, then deliver i_tx_done → remains IDLE, no further start. Next valid 16'h0102 sends 8'h02, 8'h01.
